// File: rtl/control_pkg.sv
// Shared definitions for the pipelined control unit: opcodes, ALU codes,
// the execute-stage control bundle layout and the multicycle sequencer states.
package control_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   localparam logic [4:0] ALU_ADD    = 5'd0;
   localparam logic [4:0] ALU_SUB    = 5'd1;
   localparam logic [4:0] ALU_SLL    = 5'd2;
   localparam logic [4:0] ALU_SLT    = 5'd3;
   localparam logic [4:0] ALU_SLTU   = 5'd4;
   localparam logic [4:0] ALU_XOR    = 5'd5;
   localparam logic [4:0] ALU_SRL    = 5'd6;
   localparam logic [4:0] ALU_SRA    = 5'd7;
   localparam logic [4:0] ALU_OR     = 5'd8;
   localparam logic [4:0] ALU_AND    = 5'd9;
   localparam logic [4:0] ALU_PASS_B = 5'd10;
   localparam logic [4:0] ALU_LINK   = 5'd11;
   localparam logic [4:0] ALU_EQ     = 5'd12;
   localparam logic [4:0] ALU_GE     = 5'd13;
   localparam logic [4:0] ALU_GEU    = 5'd14;
   localparam logic [4:0] ALU_MUL    = 5'd15;
   localparam logic [4:0] ALU_MULH   = 5'd16;
   localparam logic [4:0] ALU_MULHSU = 5'd17;
   localparam logic [4:0] ALU_MULHU  = 5'd18;
   localparam logic [4:0] ALU_DIV    = 5'd19;
   localparam logic [4:0] ALU_DIVU   = 5'd20;
   localparam logic [4:0] ALU_REM    = 5'd21;
   localparam logic [4:0] ALU_REMU   = 5'd22;

   localparam logic [2:0] EXT_I = 3'd0;
   localparam logic [2:0] EXT_S = 3'd1;
   localparam logic [2:0] EXT_B = 3'd2;
   localparam logic [2:0] EXT_U = 3'd3;
   localparam logic [2:0] EXT_J = 3'd4;

   localparam logic [1:0] OPA_RS1  = 2'd0;
   localparam logic [1:0] OPA_PC   = 2'd1;
   localparam logic [1:0] OPA_ZERO = 2'd2;

   // Field order is MSB first; the offsets below must track this struct.
   typedef struct packed {
      logic [6:0] opcode;
      logic [4:0] ALU_operation;
      logic [2:0] branch_op;
      logic       memRead;
      logic       memWrite;
      logic [1:0] log2_bytes;
      logic       unsigned_load;
      logic       regWrite;
      logic [1:0] operand_A_sel;
      logic       operand_B_sel;
      logic [2:0] extend_sel;
   } ctrl_t;

   localparam int CTRL_W            = $bits(ctrl_t);
   localparam int OFF_EXTEND_SEL    = 0;
   localparam int OFF_OPERAND_B_SEL = 3;
   localparam int OFF_OPERAND_A_SEL = 4;
   localparam int OFF_REGWRITE      = 6;
   localparam int OFF_UNSIGNED_LOAD = 7;
   localparam int OFF_LOG2_BYTES    = 8;
   localparam int OFF_MEMWRITE      = 10;
   localparam int OFF_MEMREAD       = 11;
   localparam int OFF_BRANCH_OP     = 12;
   localparam int OFF_ALU_OPERATION = 15;
   localparam int OFF_OPCODE        = 20;

   typedef enum logic [1:0] {
      MC_IDLE = 2'd0,
      MC_BUSY = 2'd1,
      MC_DONE = 2'd2
   } mc_state_t;

   // funct7[5] selects SUB/SRA; SUB only exists for register-register ops.
   function automatic logic [4:0] alu_from_f3(input logic [2:0] f3, input logic alt,
                                              input logic is_reg);
      logic [4:0] code;
      case (f3)
         3'b000:  code = (alt && is_reg) ? ALU_SUB : ALU_ADD;
         3'b001:  code = ALU_SLL;
         3'b010:  code = ALU_SLT;
         3'b011:  code = ALU_SLTU;
         3'b100:  code = ALU_XOR;
         3'b101:  code = alt ? ALU_SRA : ALU_SRL;
         3'b110:  code = ALU_OR;
         default: code = ALU_AND;
      endcase
      return code;
   endfunction

   function automatic logic [4:0] alu_for_branch(input logic [2:0] f3);
      logic [4:0] code;
      case (f3)
         3'b100:  code = ALU_SLT;
         3'b101:  code = ALU_GE;
         3'b110:  code = ALU_SLTU;
         3'b111:  code = ALU_GEU;
         default: code = ALU_EQ;
      endcase
      return code;
   endfunction

   function automatic logic is_m_op(input logic [4:0] code);
      return (code >= ALU_MUL) && (code <= ALU_REMU);
   endfunction

endpackage

// File: rtl/mc_sequencer.sv
// Counts the execute-stage occupancy of MUL/DIV ops and raises mc_busy while
// the op must stay in execute; DONE blocks relaunch of an op held by d_mem_hazard.
module mc_sequencer
   import control_pkg::*;
#(
   parameter int MUL_CYCLES = 2,
   parameter int DIV_CYCLES = 33
) (
   input  logic      clock,
   input  logic      reset,
   input  logic      start_i,
   input  logic      is_div_i,
   input  logic      d_mem_hazard_i,
   output logic      mc_busy_o,
   output mc_state_t state_o
);

   localparam int MAX_N = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
   localparam int CNT_W = $clog2(MAX_N + 1);
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'((MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'((DIV_CYCLES > 1) ? DIV_CYCLES - 2 : 0);
   localparam logic MUL_MULTI = (MUL_CYCLES > 1);
   localparam logic DIV_MULTI = (DIV_CYCLES > 1);

   mc_state_t        state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             multi;

   assign multi = is_div_i ? DIV_MULTI : MUL_MULTI;

   // Launch-cycle busy must be combinational so the held op freezes on its first cycle.
   always_comb begin
      mc_busy_o = 1'b0;
      case (state_q)
         MC_IDLE: mc_busy_o = start_i && multi;
         MC_BUSY: mc_busy_o = (cnt_q != '0);
         default: mc_busy_o = 1'b0;
      endcase
   end

   assign state_o = state_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= MC_IDLE;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            MC_IDLE: begin
               if (start_i) begin
                  if (multi) begin
                     cnt_q   <= is_div_i ? DIV_LOAD : MUL_LOAD;
                     state_q <= MC_BUSY;
                  end else if (d_mem_hazard_i) begin
                     state_q <= MC_DONE;
                  end
               end
            end
            MC_BUSY: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end else begin
                  state_q <= d_mem_hazard_i ? MC_DONE : MC_IDLE;
               end
            end
            MC_DONE: begin
               if (!d_mem_hazard_i) begin
                  state_q <= MC_IDLE;
               end
            end
            default: state_q <= MC_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/pipelined_control_unit.sv
// Decode-to-execute control: combinational RV32I/M decode, execute control
// register with bubble/freeze handling, PC selection and multicycle sequencing.
module pipelined_control_unit
   import control_pkg::*;
#(
   parameter int ADDRESS_BITS = 20,
   parameter int M_EXT        = 1,
   parameter int MUL_CYCLES   = 2,
   parameter int DIV_CYCLES   = 33
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [6:0]              opcode_decode,
   input  logic [2:0]              funct3,
   input  logic [6:0]              funct7,
   input  logic [ADDRESS_BITS-1:0] JAL_target_decode,
   input  logic [ADDRESS_BITS-1:0] JALR_target_execute,
   input  logic [ADDRESS_BITS-1:0] branch_target_execute,
   input  logic                    branch_execute,
   input  logic                    true_data_hazard,
   input  logic                    d_mem_hazard,
   input  logic                    i_mem_hazard,
   output logic                    ex_valid,
   output logic [CTRL_W-1:0]       ex_ctrl,
   output logic                    mc_busy,
   output logic [1:0]              next_PC_sel,
   output logic [ADDRESS_BITS-1:0] target_PC,
   output logic                    i_mem_read,
   output mc_state_t               mc_state
);

   ctrl_t dec_d;
   ctrl_t ex_ctrl_q;
   logic  ex_valid_q;
   logic  redirect;
   logic  freeze;
   logic  dec_jal;
   logic  ex_is_jalr;
   logic  ex_is_branch;

   always_comb begin
      dec_d        = '0;
      dec_d.opcode = opcode_decode;
      case (opcode_decode)
         OP_REG: begin
            dec_d.regWrite = 1'b1;
            if (funct7 == F7_MULDIV) begin
               dec_d.ALU_operation = (M_EXT != 0) ? (ALU_MUL + {2'b00, funct3}) : ALU_ADD;
            end else begin
               dec_d.ALU_operation = alu_from_f3(funct3, funct7[5], 1'b1);
            end
         end
         OP_IMM: begin
            dec_d.regWrite      = 1'b1;
            dec_d.operand_B_sel = 1'b1;
            dec_d.extend_sel    = EXT_I;
            dec_d.ALU_operation = alu_from_f3(funct3, funct7[5], 1'b0);
         end
         OP_LOAD: begin
            dec_d.memRead       = 1'b1;
            dec_d.regWrite      = 1'b1;
            dec_d.operand_B_sel = 1'b1;
            dec_d.extend_sel    = EXT_I;
            dec_d.log2_bytes    = funct3[1:0];
            dec_d.unsigned_load = funct3[2];
         end
         OP_STORE: begin
            dec_d.memWrite      = 1'b1;
            dec_d.operand_B_sel = 1'b1;
            dec_d.extend_sel    = EXT_S;
            dec_d.log2_bytes    = funct3[1:0];
         end
         OP_BRANCH: begin
            dec_d.branch_op     = funct3;
            dec_d.extend_sel    = EXT_B;
            dec_d.ALU_operation = alu_for_branch(funct3);
         end
         OP_JAL: begin
            dec_d.regWrite      = 1'b1;
            dec_d.operand_A_sel = OPA_PC;
            dec_d.extend_sel    = EXT_J;
            dec_d.ALU_operation = ALU_LINK;
         end
         OP_JALR: begin
            dec_d.regWrite      = 1'b1;
            dec_d.operand_A_sel = OPA_PC;
            dec_d.extend_sel    = EXT_I;
            dec_d.ALU_operation = ALU_LINK;
         end
         OP_LUI: begin
            dec_d.regWrite      = 1'b1;
            dec_d.operand_A_sel = OPA_ZERO;
            dec_d.operand_B_sel = 1'b1;
            dec_d.extend_sel    = EXT_U;
            dec_d.ALU_operation = ALU_PASS_B;
         end
         OP_AUIPC: begin
            dec_d.regWrite      = 1'b1;
            dec_d.operand_A_sel = OPA_PC;
            dec_d.operand_B_sel = 1'b1;
            dec_d.extend_sel    = EXT_U;
         end
         default: dec_d.opcode = opcode_decode;
      endcase
   end

   assign dec_jal      = (opcode_decode == OP_JAL);
   assign ex_is_jalr   = (ex_ctrl_q.opcode == OP_JALR);
   assign ex_is_branch = (ex_ctrl_q.opcode == OP_BRANCH);
   assign redirect     = ex_valid_q && (ex_is_jalr || (ex_is_branch && branch_execute));
   assign freeze       = d_mem_hazard || mc_busy;

   // Freeze wins over redirect, so a redirecting op is re-evaluated once released.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ex_valid_q <= 1'b0;
         ex_ctrl_q  <= '0;
      end else if (!freeze) begin
         if (redirect || true_data_hazard) begin
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
         end else begin
            ex_valid_q <= 1'b1;
            ex_ctrl_q  <= dec_d;
         end
      end
   end

   always_comb begin
      if (freeze)                next_PC_sel = 2'b01;
      else if (redirect)         next_PC_sel = 2'b10;
      else if (true_data_hazard) next_PC_sel = 2'b01;
      else if (dec_jal)          next_PC_sel = 2'b10;
      else if (i_mem_hazard)     next_PC_sel = 2'b01;
      else                       next_PC_sel = 2'b00;
   end

   always_comb begin
      if (redirect && ex_is_jalr) target_PC = JALR_target_execute;
      else if (redirect)          target_PC = branch_target_execute;
      else if (dec_jal)           target_PC = JAL_target_decode;
      else                        target_PC = '0;
   end

   mc_sequencer #(
      .MUL_CYCLES (MUL_CYCLES),
      .DIV_CYCLES (DIV_CYCLES)
   ) u_mc_sequencer (
      .clock          (clock),
      .reset          (reset),
      .start_i        (ex_valid_q && is_m_op(ex_ctrl_q.ALU_operation)),
      .is_div_i       (ex_ctrl_q.ALU_operation >= ALU_DIV),
      .d_mem_hazard_i (d_mem_hazard),
      .mc_busy_o      (mc_busy),
      .state_o        (mc_state)
   );

   assign ex_valid   = ex_valid_q;
   assign ex_ctrl    = ex_ctrl_q;
   assign i_mem_read = 1'b1;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit: decode bundles, PC selection,
// redirect/freeze priority, MUL/DIV occupancy, and reset behaviour.
module tb_pipelined_control_unit;
   import control_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [6:0]  opcode_decode = '0;
   logic [2:0]  funct3 = '0;
   logic [6:0]  funct7 = '0;
   logic [19:0] JAL_target_decode = '0;
   logic [19:0] JALR_target_execute = '0;
   logic [19:0] branch_target_execute = '0;
   logic        branch_execute = 1'b0;
   logic        true_data_hazard = 1'b0;
   logic        d_mem_hazard = 1'b0;
   logic        i_mem_hazard = 1'b0;

   logic        ex_valid, mc_busy, i_mem_read;
   logic [26:0] ex_ctrl;
   logic [1:0]  next_PC_sel;
   logic [19:0] target_PC;
   mc_state_t   mc_state;

   logic        nom_ex_valid, nom_mc_busy, nom_i_mem_read;
   logic [26:0] nom_ex_ctrl;
   logic [1:0]  nom_next_PC_sel;
   logic [19:0] nom_target_PC;
   mc_state_t   nom_mc_state;

   int checks = 0;
   int errors = 0;
   logic nom_busy_seen = 1'b0;

   always #5 clock = ~clock;

   pipelined_control_unit u_dut (
      .clock(clock), .reset(reset), .opcode_decode(opcode_decode), .funct3(funct3),
      .funct7(funct7), .JAL_target_decode(JAL_target_decode),
      .JALR_target_execute(JALR_target_execute), .branch_target_execute(branch_target_execute),
      .branch_execute(branch_execute), .true_data_hazard(true_data_hazard),
      .d_mem_hazard(d_mem_hazard), .i_mem_hazard(i_mem_hazard), .ex_valid(ex_valid),
      .ex_ctrl(ex_ctrl), .mc_busy(mc_busy), .next_PC_sel(next_PC_sel), .target_PC(target_PC),
      .i_mem_read(i_mem_read), .mc_state(mc_state)
   );

   pipelined_control_unit #(.M_EXT(0)) u_dut_nom (
      .clock(clock), .reset(reset), .opcode_decode(opcode_decode), .funct3(funct3),
      .funct7(funct7), .JAL_target_decode(JAL_target_decode),
      .JALR_target_execute(JALR_target_execute), .branch_target_execute(branch_target_execute),
      .branch_execute(branch_execute), .true_data_hazard(true_data_hazard),
      .d_mem_hazard(d_mem_hazard), .i_mem_hazard(i_mem_hazard), .ex_valid(nom_ex_valid),
      .ex_ctrl(nom_ex_ctrl), .mc_busy(nom_mc_busy), .next_PC_sel(nom_next_PC_sel),
      .target_PC(nom_target_PC), .i_mem_read(nom_i_mem_read), .mc_state(nom_mc_state)
   );

   always @(negedge clock) if (nom_mc_busy === 1'b1) nom_busy_seen = 1'b1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_dec(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
      opcode_decode = op;
      funct3        = f3;
      funct7        = f7;
      #1;
   endtask

   function automatic logic [26:0] mk(input logic [6:0] op, input logic [4:0] alu,
      input logic [2:0] br, input logic mr, input logic mw, input logic [1:0] l2,
      input logic u, input logic rw, input logic [1:0] a, input logic b, input logic [2:0] ext);
      return {op, alu, br, mr, mw, l2, u, rw, a, b, ext};
   endfunction

   localparam logic [6:0] R = 7'b0110011;
   logic [26:0] b_add, b_mul, b_div, b_lw, b_beq, b_jal;
   int busy_n;
   logic held_ok;

   initial begin
      b_add = mk(R, 5'd0, 3'd0, 0, 0, 2'd0, 0, 1, 2'd0, 0, 3'd0);
      b_mul = mk(R, 5'd15, 3'd0, 0, 0, 2'd0, 0, 1, 2'd0, 0, 3'd0);
      b_div = mk(R, 5'd19, 3'd0, 0, 0, 2'd0, 0, 1, 2'd0, 0, 3'd0);
      b_lw  = mk(7'b0000011, 5'd0, 3'd0, 1, 0, 2'd2, 0, 1, 2'd0, 1, 3'd0);
      b_beq = mk(7'b1100011, 5'd12, 3'd0, 0, 0, 2'd0, 0, 0, 2'd0, 0, 3'd2);
      b_jal = mk(7'b1101111, 5'd11, 3'd0, 0, 0, 2'd0, 0, 1, 2'd1, 0, 3'd4);

      // reset state
      set_dec(R, 3'd0, 7'd0);
      #2;
      check("rst_ex_valid", ex_valid, 0);
      check("rst_ex_ctrl", ex_ctrl, 0);
      check("rst_mc_busy", mc_busy, 0);
      check("rst_state", mc_state, MC_IDLE);
      check("rst_pc_sel", next_PC_sel, 2'b00);
      check("rst_target", target_PC, 0);
      check("i_mem_read", i_mem_read, 1);
      JAL_target_decode = 20'h12345;
      set_dec(7'b1101111, 3'd0, 7'd0);
      check("rst_jal_sel", next_PC_sel, 2'b10);
      set_dec(R, 3'd0, 7'd0);
      tick();
      tick();
      reset = 1'b1;

      tick();
      check("add_valid", ex_valid, 1);
      check("add_bundle", ex_ctrl, b_add);

      set_dec(7'b1101111, 3'd0, 7'd0);
      check("jal_sel", next_PC_sel, 2'b10);
      check("jal_target", target_PC, 20'h12345);
      tick();
      check("jal_bundle", ex_ctrl, b_jal);
      set_dec(7'b0000011, 3'b010, 7'd0);
      tick();
      check("lw_bundle", ex_ctrl, b_lw);

      // RAW hazard bubble
      set_dec(R, 3'd0, 7'd0);
      true_data_hazard = 1'b1;
      #1 check("raw_sel", next_PC_sel, 2'b01);
      tick();
      check("raw_bubble_valid", ex_valid, 0);
      check("raw_bubble_ctrl", ex_ctrl, 0);
      true_data_hazard = 1'b0;

      // fetch stall, and decode JAL outranks it
      i_mem_hazard = 1'b1;
      #1 check("imem_sel", next_PC_sel, 2'b01);
      set_dec(7'b1101111, 3'd0, 7'd0);
      check("imem_jal_sel", next_PC_sel, 2'b10);
      set_dec(R, 3'd0, 7'd0);
      i_mem_hazard = 1'b0;
      tick();

      // data memory freeze holds execute
      d_mem_hazard = 1'b1;
      set_dec(7'b0000011, 3'b010, 7'd0);
      check("dmem_sel", next_PC_sel, 2'b01);
      tick();
      check("dmem_hold", ex_ctrl, b_add);
      d_mem_hazard = 1'b0;
      set_dec(7'b1100011, 3'd0, 7'd0);
      tick();
      check("beq_bundle", ex_ctrl, b_beq);

      // taken branch redirect
      branch_execute = 1'b1;
      branch_target_execute = 20'h00400;
      set_dec(R, 3'd0, 7'd0);
      check("br_sel", next_PC_sel, 2'b10);
      check("br_target", target_PC, 20'h00400);
      tick();
      check("br_flush", ex_valid, 0);
      branch_execute = 1'b0;
      set_dec(7'b1100011, 3'd0, 7'd0);
      tick();
      set_dec(R, 3'd0, 7'd0);
      check("br_nt_sel", next_PC_sel, 2'b00);
      check("br_nt_target", target_PC, 0);

      // JALR redirect deferred by freeze
      set_dec(7'b1100111, 3'd0, 7'd0);
      tick();
      JALR_target_execute = 20'h0ABCD;
      d_mem_hazard = 1'b1;
      set_dec(R, 3'd0, 7'd0);
      check("jalr_defer_sel", next_PC_sel, 2'b01);
      tick();
      check("jalr_held", ex_valid, 1);
      d_mem_hazard = 1'b0;
      #1 check("jalr_sel", next_PC_sel, 2'b10);
      check("jalr_target", target_PC, 20'h0ABCD);
      tick();
      check("jalr_flush", ex_valid, 0);

      // MUL, two execute cycles
      set_dec(R, 3'd0, 7'b0000001);
      tick();
      check("mul_bundle", ex_ctrl, b_mul);
      check("nom_mul_alu", nom_ex_ctrl[19:15], 0);
      set_dec(R, 3'd0, 7'd0);
      check("mul_busy1", mc_busy, 1);
      check("mul_sel1", next_PC_sel, 2'b01);
      tick();
      check("mul_busy2", mc_busy, 0);
      check("mul_sel2", next_PC_sel, 2'b00);
      check("mul_state2", mc_state, MC_BUSY);
      check("mul_hold2", ex_ctrl, b_mul);
      tick();
      check("mul_next", ex_ctrl, b_add);
      check("mul_idle", mc_state, MC_IDLE);

      // DIV, 33 execute cycles
      set_dec(R, 3'b100, 7'b0000001);
      tick();
      check("div_bundle", ex_ctrl, b_div);
      set_dec(R, 3'd0, 7'd0);
      busy_n = 0;
      held_ok = 1'b1;
      while (mc_busy === 1'b1 && busy_n < 40) begin
         if (ex_ctrl !== b_div) held_ok = 1'b0;
         busy_n++;
         tick();
      end
      check("div_busy_cycles", busy_n, 32);
      check("div_held", held_ok, 1);
      check("div_last_hold", ex_ctrl, b_div);
      tick();
      check("div_next", ex_ctrl, b_add);

      // MUL completing under a 3-cycle data memory stall
      set_dec(R, 3'd0, 7'b0000001);
      tick();
      set_dec(R, 3'd0, 7'd0);
      tick();
      d_mem_hazard = 1'b1;
      tick();
      check("mulh_state_done", mc_state, MC_DONE);
      check("mulh_busy", mc_busy, 0);
      check("mulh_hold", ex_ctrl, b_mul);
      tick();
      check("mulh_state_done2", mc_state, MC_DONE);
      check("mulh_sel", next_PC_sel, 2'b01);
      tick();
      d_mem_hazard = 1'b0;
      #1 check("mulh_norelaunch", mc_busy, 0);
      check("mulh_rel_sel", next_PC_sel, 2'b00);
      tick();
      check("mulh_next", ex_ctrl, b_add);
      check("mulh_idle", mc_state, MC_IDLE);

      // reset in the middle of a DIV
      set_dec(R, 3'b100, 7'b0000001);
      tick();
      set_dec(R, 3'd0, 7'd0);
      tick();
      tick();
      check("div2_busy", mc_busy, 1);
      reset = 1'b0;
      #1 check("midrst_valid", ex_valid, 0);
      check("midrst_busy", mc_busy, 0);
      check("midrst_state", mc_state, MC_IDLE);
      tick();
      reset = 1'b1;
      tick();
      check("postrst_bundle", ex_ctrl, b_add);
      check("postrst_busy", mc_busy, 0);

      check("nom_never_busy", nom_busy_seen, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
